// File: rtl/alarm_clock_pio_out_pkg.sv
// Shared definitions for the alarm clock output PIO: register map and
// pulse timer state encoding. The input PIO reuses the address constants.
package alarm_clock_pio_out_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_MASK     = 3'd1;
  localparam logic [2:0] ADDR_LEN      = 3'd2;
  localparam logic [2:0] ADDR_STATUS   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } pulse_state_e;

endpackage

// File: rtl/pio_pulse_timer.sv
// One-shot pulse timer: loads a length, counts down, and flags expiry for
// one cycle when the count reaches its terminal value of 1.
//
// state | meaning
// IDLE  | no pulse in flight, counter held at 0
// COUNT | pulse in flight, counter = cycles left before expiry
module pio_pulse_timer
  import alarm_clock_pio_out_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] len,
  output logic                 expire,
  output logic                 busy
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  pulse_state_e         state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: a load always (re)starts the count and suppresses expiry,
  // so a retrigger landing on the terminal cycle simply extends the pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    expire  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (load && (len != '0)) begin
          state_d = COUNT;
          cnt_d   = len;
        end
      end
      COUNT: begin
        if (load && (len != '0)) begin
          cnt_d = len;
        end else if (cnt_q == CNT_ONE) begin
          expire  = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy = (state_q == COUNT);

endmodule

// File: rtl/alarm_clock_pio_out.sv
// Avalon-MM output PIO for the alarm clock: DATA register with atomic
// set/clear writes, plus a pulse timer that auto-clears masked bits so the
// CPU can fire buzzer chirps without timing them itself.
module alarm_clock_pio_out
  import alarm_clock_pio_out_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH      = 8,
  parameter logic [DATA_WIDTH-1:0]  RESET_VALUE     = '0,
  parameter int unsigned            CNT_WIDTH       = 16,
  parameter logic [CNT_WIDTH-1:0]   PULSE_LEN_RESET = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  pulse_busy
);

  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] mask_q;
  logic [CNT_WIDTH-1:0]  len_q;

  logic                  wr_en;
  logic                  cpu_data_wr;
  logic [DATA_WIDTH-1:0] cpu_data_nxt;
  logic [DATA_WIDTH-1:0] rise;
  logic                  trigger;
  logic                  expire;
  logic                  unused_wd;

  assign wr_en = chipselect & ~write_n;

  // Bits above the register widths are ignored by design.
  assign unused_wd = ^writedata;

  // Decode CPU writes that change DATA and compute the value they produce.
  always_comb begin
    cpu_data_wr  = 1'b0;
    cpu_data_nxt = data_q;
    if (wr_en) begin
      case (address)
        ADDR_DATA: begin
          cpu_data_wr  = 1'b1;
          cpu_data_nxt = writedata[DATA_WIDTH-1:0];
        end
        ADDR_OUTSET: begin
          cpu_data_wr  = 1'b1;
          cpu_data_nxt = data_q | writedata[DATA_WIDTH-1:0];
        end
        ADDR_OUTCLEAR: begin
          cpu_data_wr  = 1'b1;
          cpu_data_nxt = data_q & ~writedata[DATA_WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  // A pulse starts only on a rising masked bit; rewriting an already-high
  // bit does not retrigger.
  assign rise    = cpu_data_nxt & ~data_q & mask_q;
  assign trigger = cpu_data_wr && (|rise) && (len_q != '0);

  pio_pulse_timer #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_pulse_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (trigger),
    .len    (len_q),
    .expire (expire),
    .busy   (pulse_busy)
  );

  // DATA update: CPU write beats timer expiry for every bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= RESET_VALUE;
    end else if (cpu_data_wr) begin
      data_q <= cpu_data_nxt;
    end else if (expire) begin
      data_q <= data_q & ~mask_q;
    end
  end

  // Configuration registers; LEN is only sampled by the timer on a load.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q <= '0;
      len_q  <= PULSE_LEN_RESET;
    end else if (wr_en) begin
      if (address == ADDR_MASK) mask_q <= writedata[DATA_WIDTH-1:0];
      if (address == ADDR_LEN)  len_q  <= writedata[CNT_WIDTH-1:0];
    end
  end

  // Read mux registered every cycle, no read strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
    end else begin
      case (address)
        ADDR_DATA:   readdata <= 32'(data_q);
        ADDR_MASK:   readdata <= 32'(mask_q);
        ADDR_LEN:    readdata <= 32'(len_q);
        ADDR_STATUS: readdata <= {31'b0, pulse_busy};
        default:     readdata <= '0;
      endcase
    end
  end

  assign out_port = data_q;

endmodule

// File: tb/tb_alarm_clock_pio_out.sv
// Bench for alarm_clock_pio_out: directed scenarios followed by random bus
// traffic, all checked against a cycle-time reference model.
module tb_alarm_clock_pio_out;
  import alarm_clock_pio_out_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  logic        pulse_busy;

  int errors = 0;
  int checks = 0;

  // Reference model: register contents plus the absolute cycle at which a
  // running pulse ends.
  logic [7:0]  m_data;
  logic [7:0]  m_mask;
  logic [15:0] m_len;
  logic        m_busy;
  int          m_exp;
  int          cyc = 0;

  alarm_clock_pio_out dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .pulse_busy (pulse_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic step(input logic rst, input logic cs, input logic wn,
                      input logic [2:0] a, input logic [31:0] wd);
    logic [31:0] exp_rd;
    logic        wr, dwr, trig, expn;
    logic [7:0]  nd;
    reset = rst; chipselect = cs; write_n = wn; address = a; writedata = wd;
    @(posedge clk);
    #1;
    cyc++;
    case (a)
      ADDR_DATA:   exp_rd = {24'b0, m_data};
      ADDR_MASK:   exp_rd = {24'b0, m_mask};
      ADDR_LEN:    exp_rd = {16'b0, m_len};
      ADDR_STATUS: exp_rd = {31'b0, m_busy};
      default:     exp_rd = 32'b0;
    endcase
    if (rst) begin
      m_data = 8'h00; m_mask = 8'h00; m_len = 16'h0000; m_busy = 1'b0;
      exp_rd = 32'b0;
    end else begin
      wr  = cs && !wn;
      dwr = 1'b0;
      nd  = m_data;
      if (wr && a == ADDR_DATA)     begin dwr = 1'b1; nd = wd[7:0]; end
      if (wr && a == ADDR_OUTSET)   begin dwr = 1'b1; nd = m_data | wd[7:0]; end
      if (wr && a == ADDR_OUTCLEAR) begin dwr = 1'b1; nd = m_data & ~wd[7:0]; end
      trig = dwr && ((nd & ~m_data & m_mask) != 8'h00) && (m_len != 16'h0000);
      expn = m_busy && (cyc == m_exp);
      if (dwr) begin
        m_data = nd;
        if (trig) begin
          m_busy = 1'b1;
          m_exp  = cyc + int'(m_len);
        end else if (expn) begin
          m_busy = 1'b0;
        end
      end else if (expn) begin
        m_data = m_data & ~m_mask;
        m_busy = 1'b0;
      end
      if (wr && a == ADDR_MASK) m_mask = wd[7:0];
      if (wr && a == ADDR_LEN)  m_len  = wd[15:0];
    end
    chk("model_out_port", {24'b0, out_port}, {24'b0, m_data});
    chk("model_busy", {31'b0, pulse_busy}, {31'b0, m_busy});
    chk("model_readdata", readdata, exp_rd);
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] wd);
    step(1'b0, 1'b1, 1'b0, a, wd);
  endtask

  task automatic idle(input logic [2:0] a);
    step(1'b0, 1'b0, 1'b1, a, 32'h0);
  endtask

  initial begin
    int hi, bz;
    logic [2:0] ra;
    logic [31:0] rwd;
    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = 32'h0;
    m_data = 8'h00; m_mask = 8'h00; m_len = 16'h0000; m_busy = 1'b0; m_exp = 0;

    // reset state and register readback
    step(1'b1, 1'b0, 1'b1, ADDR_DATA, 32'h0);
    chk("rst_out_port", {24'b0, out_port}, 32'h0);
    idle(ADDR_DATA);   chk("rst_rd_data", readdata, 32'h0);
    idle(ADDR_MASK);   chk("rst_rd_mask", readdata, 32'h0);
    idle(ADDR_LEN);    chk("rst_rd_len", readdata, 32'h0);
    idle(ADDR_STATUS); chk("rst_rd_status", readdata, 32'h0);

    // DATA, OUTSET, OUTCLEAR
    wr_reg(ADDR_DATA, 32'hFFFF_FFA5);   chk("data_a5", {24'b0, out_port}, 32'hA5);
    wr_reg(ADDR_OUTSET, 32'h0A);        chk("outset_af", {24'b0, out_port}, 32'hAF);
    wr_reg(ADDR_OUTCLEAR, 32'h81);      chk("outclr_2e", {24'b0, out_port}, 32'h2E);
    idle(ADDR_OUTSET);                  chk("rd_outset_0", readdata, 32'h0);

    // single pulse of length 5
    wr_reg(ADDR_MASK, 32'h01);
    wr_reg(ADDR_LEN, 32'h5);
    wr_reg(ADDR_OUTSET, 32'h01);
    hi = int'(out_port[0]); bz = int'(pulse_busy);
    for (int i = 0; i < 8; i++) begin
      idle(ADDR_STATUS);
      hi += int'(out_port[0]); bz += int'(pulse_busy);
    end
    chk("pulse_width", hi, 5);
    chk("pulse_busy_width", bz, 5);
    chk("pulse_other_bits", {24'b0, out_port}, 32'h2E);

    // retrigger extends the pulse
    wr_reg(ADDR_OUTSET, 32'h01);   bz = int'(pulse_busy);
    idle(ADDR_STATUS);             bz += int'(pulse_busy);
    wr_reg(ADDR_OUTCLEAR, 32'h01); bz += int'(pulse_busy);
    wr_reg(ADDR_OUTSET, 32'h01);   bz += int'(pulse_busy); hi = int'(out_port[0]);
    for (int i = 0; i < 8; i++) begin
      idle(ADDR_STATUS);
      bz += int'(pulse_busy); hi += int'(out_port[0]);
    end
    chk("retrig_busy_total", bz, 8);
    chk("retrig_bit0_width", hi, 5);

    // CPU write colliding with expiry
    wr_reg(ADDR_DATA, 32'h00);
    wr_reg(ADDR_MASK, 32'h0F);
    wr_reg(ADDR_LEN, 32'h3);
    wr_reg(ADDR_OUTSET, 32'h02);
    idle(ADDR_DATA);
    idle(ADDR_DATA);
    wr_reg(ADDR_DATA, 32'hF0);
    chk("collide_out_f0", {24'b0, out_port}, 32'hF0);
    chk("collide_idle", {31'b0, pulse_busy}, 32'h0);
    wr_reg(ADDR_OUTSET, 32'h02);
    idle(ADDR_DATA);
    idle(ADDR_DATA);
    wr_reg(ADDR_DATA, 32'hF1);
    chk("collide_out_f1", {24'b0, out_port}, 32'hF1);
    chk("collide_reload_busy", {31'b0, pulse_busy}, 32'h1);
    idle(ADDR_DATA);
    idle(ADDR_DATA);
    chk("collide_still_busy", {31'b0, pulse_busy}, 32'h1);
    idle(ADDR_DATA);
    chk("collide_expired", {31'b0, pulse_busy}, 32'h0);
    chk("collide_cleared", {24'b0, out_port}, 32'hF0);

    // reset in the middle of a long count
    wr_reg(ADDR_MASK, 32'h01);
    wr_reg(ADDR_LEN, 32'd100);
    wr_reg(ADDR_DATA, 32'h00);
    wr_reg(ADDR_OUTSET, 32'h01);
    for (int i = 0; i < 39; i++) idle(ADDR_STATUS);
    chk("midcount_busy", {31'b0, pulse_busy}, 32'h1);
    step(1'b1, 1'b0, 1'b1, ADDR_STATUS, 32'h0);
    chk("midrst_out", {24'b0, out_port}, 32'h0);
    chk("midrst_busy", {31'b0, pulse_busy}, 32'h0);
    idle(ADDR_STATUS);
    chk("midrst_status", readdata, 32'h0);

    // random bus traffic
    for (int i = 0; i < 1500; i++) begin
      ra  = 3'($urandom_range(0, 7));
      rwd = $urandom;
      if (ra == ADDR_LEN && $urandom_range(0, 7) != 0) rwd = 32'($urandom_range(0, 9));
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) == 0), ra, rwd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
